// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low glyph table and reader FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Index is the hex nibble; bit order {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    HELD
  } state_e;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    return SEG_PAT[nib];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Inverse of the segment encoder table: active-low pattern to nibble / known / blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] nibble,
  output logic       known,
  output logic       blank
);

  always_comb begin
    nibble = '0;
    known  = 1'b0;
    blank  = (pat == SEG_BLANK);
    for (int unsigned i = 0; i < 16; i++) begin
      if (pat == SEG_PAT[i]) begin
        nibble = 4'(i);
        known  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_reader.sv
// Reconstructs the hex word on a multiplexed active-low seven-segment bus,
// committing a digit only after its pattern has been stable for STABLE_CYCLES samples.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
  input  logic                  err_clr,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_valid,
  output logic [DIGITS-1:0]     digit_blank,
  output logic                  commit,
  output logic                  frame_done,
  output logic                  err,
  output logic [2:0]            err_digit
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]          s_seg_q, s_seg_d;
  logic [DIGITS-1:0]   s_an_q, s_an_d;
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          cur_sel_q, cur_sel_d;
  logic [6:0]          cur_pat_q, cur_pat_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   valid_q, valid_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic                commit_q, commit_d;
  logic                frame_q, frame_d;
  logic                err_q, err_d;
  logic [2:0]          err_digit_q, err_digit_d;

  logic [3:0]          zero_cnt;
  logic [2:0]          sel_idx;
  logic                sel_ok;
  logic                same;
  logic                do_commit;
  logic [DIGITS-1:0]   seen_set;
  logic [3:0]          dec_nibble;
  logic                dec_known;
  logic                dec_blank;

  seg7_decode u_decode (
    .pat    (cur_pat_q),
    .nibble (dec_nibble),
    .known  (dec_known),
    .blank  (dec_blank)
  );

  always_comb begin
    s_seg_d  = seg_n;
    s_an_d   = an_n;
    zero_cnt = '0;
    sel_idx  = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!s_an_q[i]) begin
        zero_cnt = zero_cnt + 4'd1;
        sel_idx  = 3'(i);
      end
    end
    sel_ok = (zero_cnt == 4'd1);
    same   = (sel_idx == cur_sel_q) && (s_seg_q == cur_pat_q);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_sel_d = cur_sel_q;
    cur_pat_d = cur_pat_q;
    do_commit = 1'b0;
    if (!sel_ok) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        TRACK: begin
          if (same) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              do_commit = 1'b1;
              state_d   = HELD;
            end
          end else begin
            cur_sel_d = sel_idx;
            cur_pat_d = s_seg_q;
            cnt_d     = CNT_W'(1);
          end
        end
        HELD: begin
          if (!same) begin
            cur_sel_d = sel_idx;
            cur_pat_d = s_seg_q;
            cnt_d     = CNT_W'(1);
            state_d   = TRACK;
          end
        end
        default: begin
          cur_sel_d = sel_idx;
          cur_pat_d = s_seg_q;
          cnt_d     = CNT_W'(1);
          state_d   = TRACK;
        end
      endcase
    end
  end

  // The committed pattern is cur_pat_q, which equals s_seg_q whenever do_commit is set.
  always_comb begin
    value_d     = value_q;
    valid_d     = valid_q;
    blank_d     = blank_q;
    seen_d      = seen_q;
    seen_set    = seen_q;
    commit_d    = do_commit;
    frame_d     = 1'b0;
    err_d       = err_q & ~err_clr;
    err_digit_d = err_digit_q;
    if (do_commit) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (3'(i) == cur_sel_q) begin
          seen_set[i] = 1'b1;
          if (dec_known) begin
            value_d[4*i +: 4] = dec_nibble;
            valid_d[i]        = 1'b1;
            blank_d[i]        = 1'b0;
          end else if (dec_blank) begin
            value_d[4*i +: 4] = '0;
            valid_d[i]        = 1'b0;
            blank_d[i]        = 1'b1;
          end else begin
            valid_d[i] = 1'b0;
            blank_d[i] = 1'b0;
          end
        end
      end
      if (&seen_set) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end else begin
        seen_d = seen_set;
      end
      if (!dec_known && !dec_blank) begin
        err_d       = 1'b1;
        err_digit_d = cur_sel_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg_q     <= '1;
      s_an_q      <= '1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_sel_q   <= '0;
      cur_pat_q   <= '1;
      value_q     <= '0;
      valid_q     <= '0;
      blank_q     <= '0;
      seen_q      <= '0;
      commit_q    <= 1'b0;
      frame_q     <= 1'b0;
      err_q       <= 1'b0;
      err_digit_q <= '0;
    end else begin
      s_seg_q     <= s_seg_d;
      s_an_q      <= s_an_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_sel_q   <= cur_sel_d;
      cur_pat_q   <= cur_pat_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      blank_q     <= blank_d;
      seen_q      <= seen_d;
      commit_q    <= commit_d;
      frame_q     <= frame_d;
      err_q       <= err_d;
      err_digit_q <= err_digit_d;
    end
  end

  assign value       = value_q;
  assign digit_valid = valid_q;
  assign digit_blank = blank_q;
  assign commit      = commit_q;
  assign frame_done  = frame_q;
  assign err         = err_q;
  assign err_digit   = err_digit_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Scoreboard bench for seg7_reader: a sample-run model predicts each commit and its timing.
module tb_seg7_reader;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        err_clr;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic [3:0]  digit_blank;
  logic        commit;
  logic        frame_done;
  logic        err;
  logic [2:0]  err_digit;

  seg7_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .err_clr     (err_clr),
    .value       (value),
    .digit_valid (digit_valid),
    .digit_blank (digit_blank),
    .commit      (commit),
    .frame_done  (frame_done),
    .err         (err),
    .err_digit   (err_digit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [6:0] pat_tb [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct {
    int          cyc;
    logic [2:0]  dig;
    logic [15:0] val;
    logic [3:0]  vld;
    logic [3:0]  blk;
    logic        frame;
    logic        unk;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_errors = 0;

  logic [10:0] last_key;
  int          run_len;
  logic [15:0] m_val;
  logic [3:0]  m_vld, m_blk, m_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic an_ok(input logic [3:0] an);
    int z = 0;
    for (int i = 0; i < DIGITS; i++) if (!an[i]) z++;
    return z == 1;
  endfunction

  task automatic model_reset();
    last_key = 11'h7FF;
    run_len  = 0;
    m_val    = '0;
    m_vld    = '0;
    m_blk    = '0;
    m_seen   = '0;
    sb.delete();
  endtask

  task automatic model_step(input logic [3:0] an, input logic [6:0] seg);
    exp_t e;
    int   d;
    int   nib;
    logic known;
    if ({an, seg} == last_key) run_len++;
    else begin
      run_len  = 1;
      last_key = {an, seg};
    end
    if (an_ok(an) && run_len == STABLE) begin
      d = 0;
      for (int i = 0; i < DIGITS; i++) if (!an[i]) d = i;
      known = 1'b0;
      nib   = 0;
      for (int k = 0; k < 16; k++) if (seg == pat_tb[k]) begin known = 1'b1; nib = k; end
      e.unk = 1'b0;
      if (known) begin
        m_val[4*d +: 4] = 4'(nib);
        m_vld[d] = 1'b1;
        m_blk[d] = 1'b0;
      end else if (seg == 7'h7F) begin
        m_val[4*d +: 4] = 4'h0;
        m_vld[d] = 1'b0;
        m_blk[d] = 1'b1;
      end else begin
        m_vld[d] = 1'b0;
        m_blk[d] = 1'b0;
        e.unk = 1'b1;
      end
      m_seen[d] = 1'b1;
      e.frame = &m_seen;
      if (e.frame) m_seen = '0;
      e.cyc = cyc + 2;
      e.dig = 3'(d);
      e.val = m_val;
      e.vld = m_vld;
      e.blk = m_blk;
      sb.push_back(e);
    end
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n, input int clr_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      an_n    = an;
      seg_n   = seg;
      err_clr = (i == clr_at);
      model_step(an, seg);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) hold(an_n, seg_n, 1, -1);
    check("drain", sb.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    err_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_step(an_n, seg_n);
  endtask

  always @(negedge clk) begin
    if (commit) begin
      if (sb.size() == 0) check("unexp_commit", commit, 1'b0);
      else begin
        mon_e = sb.pop_front();
        check("commit_cyc", cyc, mon_e.cyc);
        check("value", value, mon_e.val);
        check("digit_valid", digit_valid, mon_e.vld);
        check("digit_blank", digit_blank, mon_e.blk);
        check("frame_done", frame_done, mon_e.frame);
        if (mon_e.unk) begin
          check("err_on_commit", err, 1'b1);
          check("err_digit", err_digit, mon_e.dig);
        end
      end
    end else begin
      check("frame_idle", frame_done, 1'b0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    an_n    = '1;
    seg_n   = '1;
    err_clr = 1'b0;
    model_reset();
    do_reset();
    check("rst_value", value, 16'h0);
    check("rst_valid", digit_valid, 4'h0);
    check("rst_blank", digit_blank, 4'h0);
    check("rst_commit", commit, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_err_digit", err_digit, 3'd0);

    hold(4'b1110, 7'b0110000, 10, -1);
    drain();
    check("single_nibble", value[3:0], 4'h3);
    check("single_valid", digit_valid, 4'b0001);

    hold(4'b1110, 7'b1111001, 6, -1);
    hold(4'b1101, 7'b0001000, 6, -1);
    hold(4'b1011, 7'b1111111, 6, -1);
    hold(4'b0111, 7'b0001110, 6, -1);
    drain();
    check("scan_value", value, 16'hF0A1);
    check("scan_valid", digit_valid, 4'b1011);
    check("scan_blank", digit_blank, 4'b0100);

    hold(4'b1101, 7'b0010010, 3, -1);
    hold(4'b1101, 7'b0000010, 1, -1);
    hold(4'b1101, 7'b0010010, 3, -1);
    hold(4'b1110, 7'b0000010, 3, -1);
    hold(4'b1101, 7'b0010010, 5, -1);
    drain();
    check("glitch_value", value, m_val);

    hold(4'b1100, 7'b0110000, 8, -1);
    hold(4'b1111, 7'b0110000, 8, -1);
    check("invalid_value", value, m_val);
    check("invalid_valid", digit_valid, m_vld);
    check("invalid_blank", digit_blank, m_blk);

    hold(4'b1011, 7'b1010101, 6, -1);
    drain();
    check("err_set", err, 1'b1);
    check("err_digit2", err_digit, 3'd2);
    check("err_valid2", digit_valid[2], 1'b0);
    hold(4'b1011, 7'b1010101, 1, 0);
    hold(4'b1011, 7'b1010101, 1, -1);
    check("err_cleared", err, 1'b0);
    check("err_digit_kept", err_digit, 3'd2);
    hold(4'b1011, 7'b0101010, 6, 4);
    drain();
    check("err_clr_loses", err, 1'b1);

    for (int k = 0; k < 16; k++) hold(4'b1110, pat_tb[k], 5, -1);
    drain();
    check("exh_last", value[3:0], 4'hF);

    hold(4'b0111, 7'b0100100, 2, -1);
    do_reset();
    check("midrst_value", value, 16'h0);
    hold(4'b0111, 7'b0100100, 6, -1);
    drain();
    check("midrst_digit3", value[15:12], 4'h2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
